mem_stage_dmem_ctrl: RTL and testbench

- MEM-stage data-memory controller of the RV32IM pipeline, directly downstream of the EX/MEM pipeline register.
- Decodes load/store control from EX/MEM and runs a req/ack handshake to the word-wide data memory.
- Generates store byte-enables and load sign/zero extension.
- Drives busy_wait to stall every pipeline register while an access is outstanding, and flags misaligned or timed-out accesses.

---
 rtl/mem_stage_dmem_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage_dmem_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_dmem_ctrl
//   MEM-stage data-memory controller for the RV32IM pipeline. It sits right
//   after the EX/MEM register. It decodes the load/store control and runs one
//   access to a word-wide data memory at a time. It produces the store byte
//   enables and write data, and it sign/zero-extends load results. While an
//   access is outstanding it raises o_busy_wait to stall the pipeline.
//
//   Memory handshake: o_mem_req is the request "valid". Once o_mem_req is
//   raised, it stays high and o_mem_addr/o_mem_we/o_mem_be/o_mem_wdata stay
//   stable until the memory returns a one-cycle i_mem_ack (the "ready"). The
//   handshake also ends when the wait counter reaches TIMEOUT_CYCLES. An ack
//   seen outside WAIT is ignored.
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   i_datamemsel       : EX/MEM instruction accesses memory
//   i_read_write[3:0]  : [3] 1=store/0=load, [2:0] funct3
//   i_addr             : byte address
//   i_store_data       : rs2 value, right-aligned
//   o_busy_wait        : combinational stall request
//   o_load_data        : extended load result for MEM/WB
//   o_err_misalign     : one-cycle pulse, misaligned access rejected
//   o_err_timeout      : one-cycle pulse, access aborted after timeout
//   o_mem_req/we/addr/wdata/be : registered request to data memory
//   i_mem_rdata, i_mem_ack     : memory response
//   o_dbg_state        : current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ----------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_datamemsel,
    input  logic [3:0]  i_read_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_busy_wait,
    output logic [31:0] o_load_data,
    output logic        o_err_misalign,
    output logic        o_err_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_mem_req, r_mem_we, r_err_misalign, r_err_timeout;
    logic [31:0] r_mem_addr, r_mem_wdata, r_load_data;
    logic [3:0]  r_mem_be;

    logic [2:0]  w_funct3;
    logic        w_valid_f3, w_misalign, w_start, w_bad;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [31:0] w_load_ext;
    logic [7:0]  w_cnt_next;
    logic        w_timeout;
    logic        w_busy;

    // ---------------- request decode ----------------
    assign w_funct3   = i_read_write[2:0];
    // 011, 110 and 111 are not load/store widths; they act as a no-op.
    assign w_valid_f3 = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);

    always_comb begin
        w_misalign = 1'b0;
        case (w_funct3[1:0])
            2'b01:   w_misalign = i_addr[0];
            2'b10:   w_misalign = |i_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_start = i_datamemsel && w_valid_f3 && !w_misalign;
    assign w_bad   = i_datamemsel && w_valid_f3 &&  w_misalign;

    // Store lane placement: replicate the data across the word so that the
    // byte enables alone select the lanes that get written.
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = i_store_data;
        case (w_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << i_addr[1:0];
                w_st_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << i_addr[1:0];
                w_st_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- load extraction (latched width/offset) ----------------
    always_comb begin
        w_rbyte = i_mem_rdata[7:0];
        case (r_off)
            2'd1:    w_rbyte = i_mem_rdata[15:8];
            2'd2:    w_rbyte = i_mem_rdata[23:16];
            2'd3:    w_rbyte = i_mem_rdata[31:24];
            default: w_rbyte = i_mem_rdata[7:0];
        endcase
        w_rhalf = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_rbyte[7]}}, w_rbyte};
            3'b001:  w_load_ext = {{16{w_rhalf[15]}}, w_rhalf};
            3'b100:  w_load_ext = {24'd0, w_rbyte};
            3'b101:  w_load_ext = {16'd0, w_rhalf};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    // Timeout fires on the WAIT cycle that makes TIMEOUT_CYCLES request cycles.
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == LP_TIMEOUT);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = w_start;
                if (w_start) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (i_mem_ack || w_timeout) w_state_next = S_DONE;
            end
            // DONE lets the pipeline advance. The finished access is still on
            // the inputs here, so it must not be decoded again.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= 8'd0;
            r_funct3       <= 3'd0;
            r_off          <= 2'd0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_wdata    <= 32'd0;
            r_mem_be       <= 4'd0;
            r_load_data    <= 32'd0;
            r_err_misalign <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_err_misalign <= (r_state == S_IDLE) && w_bad;
            r_err_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_read_write[3];
                        r_mem_addr  <= {i_addr[31:2], 2'b00};
                        r_mem_be    <= i_read_write[3] ? w_st_be : 4'b0000;
                        r_mem_wdata <= w_st_wdata;
                        r_funct3    <= w_funct3;
                        r_off       <= i_addr[1:0];
                        r_cnt       <= 8'd0;
                    end else if (w_bad) begin
                        r_load_data <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) r_load_data <= w_load_ext;
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_load_data   <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy_wait    = w_busy && !reset;
    assign o_load_data    = r_load_data;
    assign o_err_misalign = r_err_misalign;
    assign o_err_timeout  = r_err_timeout;
    assign o_mem_req      = r_mem_req;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_mem_be       = r_mem_be;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
module tb_mem_stage_dmem_ctrl;

    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        datamemsel;
    logic [3:0]  read_write;
    logic [31:0] addr, store_data;
    logic        busy_wait;
    logic [31:0] load_data;
    logic        err_misalign, err_timeout;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mem_stage_dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_datamemsel  (datamemsel),
        .i_read_write  (read_write),
        .i_addr        (addr),
        .i_store_data  (store_data),
        .o_busy_wait   (busy_wait),
        .o_load_data   (load_data),
        .o_err_misalign(err_misalign),
        .o_err_timeout (err_timeout),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_be      (mem_be),
        .i_mem_rdata   (mem_rdata),
        .i_mem_ack     (mem_ack),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_load(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check_eq(tag, load_data, e);
    endtask

    // ---------------- driver tasks ----------------
    int          a_busy, a_req;
    logic [3:0]  a_be;
    logic [31:0] a_wd, a_ma;
    logic        a_we, a_tmo, a_stable;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one EX/MEM access and plays the memory side. ack_at is the WAIT
    // cycle index (0 = first) on which mem_ack is given, or -1 for never.
    // Returns in the cycle after busy_wait first drops, with inputs cleared.
    task automatic run_access(input logic [3:0] rw, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int ack_at);
        int waits = 0;
        bit done  = 1'b0;
        a_busy = 0; a_req = 0; a_be = '0; a_wd = '0; a_ma = '0;
        a_we = 1'b0; a_tmo = 1'b0; a_stable = 1'b1;
        datamemsel = 1'b1; read_write = rw; addr = a; store_data = sd; mem_rdata = rd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mem_ack = mem_req && (waits == ack_at);
            #1;
            if (busy_wait) a_busy++;
            if (mem_req) begin
                if (a_req == 0) begin
                    a_be = mem_be; a_wd = mem_wdata; a_ma = mem_addr; a_we = mem_we;
                end else if (mem_be !== a_be || mem_wdata !== a_wd ||
                             mem_addr !== a_ma || mem_we !== a_we) begin
                    a_stable = 1'b0;
                end
                a_req++;
                waits++;
            end
            if (!busy_wait) begin
                a_tmo = err_timeout;
                done  = 1'b1;
            end else begin
                step();
            end
        end
        check_eq("access_terminates", {31'd0, done}, 32'd1);
        step();
        mem_ack = 1'b0; datamemsel = 1'b0; read_write = 4'd0; addr = '0; store_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; datamemsel = 1'b1; read_write = 4'b0010; addr = 32'h100;
        store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) step();
        #1;
        check_eq("rst_busy",   {31'd0, busy_wait}, 32'd0);
        check_eq("rst_req",    {31'd0, mem_req},   32'd0);
        check_eq("rst_load",   load_data,          32'd0);
        check_eq("rst_addr",   mem_addr,           32'd0);
        check_eq("rst_be",     {28'd0, mem_be},    32'd0);
        check_eq("rst_state",  {30'd0, dbg_state}, 32'd0);
        reset = 1'b0; datamemsel = 1'b0;
        step();

        // SW 0x100, single-cycle ack
        run_access(4'b1010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        check_eq("sw_busy",   a_busy,  32'd2);
        check_eq("sw_req",    a_req,   32'd1);
        check_eq("sw_be",     {28'd0, a_be}, 32'hF);
        check_eq("sw_addr",   a_ma,    32'h100);
        check_eq("sw_wdata",  a_wd,    32'hDEADBEEF);
        check_eq("sw_we",     {31'd0, a_we}, 32'd1);
        check_eq("sw_load",   load_data, 32'd0);
        check_eq("sw_state",  {30'd0, dbg_state}, 32'd0);

        // SB 0x103
        run_access(4'b1000, 32'h103, 32'h000000A5, 32'h0, 0);
        check_eq("sb_be",     {28'd0, a_be}, 32'h8);
        check_eq("sb_wdata",  a_wd, 32'hA5A5A5A5);
        check_eq("sb_addr",   a_ma, 32'h100);

        // SH 0x102
        run_access(4'b1001, 32'h102, 32'h0000BEEF, 32'h0, 0);
        check_eq("sh_be",     {28'd0, a_be}, 32'hC);
        check_eq("sh_wdata",  a_wd, 32'hBEEFBEEF);

        // Loads from 0x102 / 0x100
        exp_q.push_back(32'hFFFFFFF4);
        run_access(4'b0000, 32'h102, 32'h0, 32'h12F45678, 0);
        check_load("lb_data");
        check_eq("lb_be", {28'd0, a_be}, 32'd0);
        check_eq("lb_we", {31'd0, a_we}, 32'd0);
        exp_q.push_back(32'h000000F4);
        run_access(4'b0100, 32'h102, 32'h0, 32'h12F45678, 0);
        check_load("lbu_data");
        exp_q.push_back(32'h000012F4);
        run_access(4'b0001, 32'h102, 32'h0, 32'h12F45678, 0);
        check_load("lh_data");
        exp_q.push_back(32'h00005678);
        run_access(4'b0101, 32'h100, 32'h0, 32'h12F45678, 0);
        check_load("lhu_data");
        exp_q.push_back(32'hFFFF8001);
        run_access(4'b0001, 32'h100, 32'h0, 32'h12348001, 0);
        check_load("lh_neg");
        exp_q.push_back(32'h89ABCDEF);
        run_access(4'b0010, 32'h104, 32'h0, 32'h89ABCDEF, 0);
        check_load("lw_data");
        check_eq("lw_addr", a_ma, 32'h104);

        // Store leaves load_data alone
        run_access(4'b1010, 32'h110, 32'h11112222, 32'h0, 0);
        check_eq("st_keeps_load", load_data, 32'h89ABCDEF);

        // Ack on third WAIT cycle
        exp_q.push_back(32'h0BADF00D);
        run_access(4'b0010, 32'h108, 32'h0, 32'h0BADF00D, 2);
        check_eq("slow_busy",   a_busy, 32'd4);
        check_eq("slow_req",    a_req,  32'd3);
        check_eq("slow_stable", {31'd0, a_stable}, 32'd1);
        check_load("slow_data");

        // Misaligned LW 0x106
        run_access(4'b0010, 32'h106, 32'h0, 32'h0, 0);
        check_eq("mis_busy", a_busy, 32'd0);
        check_eq("mis_req",  a_req,  32'd0);
        #1;
        check_eq("mis_err",  {31'd0, err_misalign}, 32'd1);
        check_eq("mis_load", load_data, 32'd0);
        step();
        check_eq("mis_pulse", {31'd0, err_misalign}, 32'd0);

        // Misaligned LH 0x101
        run_access(4'b0001, 32'h101, 32'h0, 32'h0, 0);
        #1;
        check_eq("mis_lh_err", {31'd0, err_misalign}, 32'd1);
        step();

        // Unused funct3 011: no-op
        run_access(4'b0011, 32'h100, 32'h0, 32'h0, 0);
        check_eq("nop_busy", a_busy, 32'd0);
        check_eq("nop_req",  a_req,  32'd0);
        #1;
        check_eq("nop_err",  {31'd0, err_misalign}, 32'd0);
        step();

        // Timeout: load something first, then never ack
        exp_q.push_back(32'h13579BDF);
        run_access(4'b0010, 32'h10C, 32'h0, 32'h13579BDF, 0);
        check_load("pre_tmo_load");
        run_access(4'b0010, 32'h200, 32'h0, 32'hFFFFFFFF, -1);
        check_eq("tmo_req",   a_req, TMO);
        check_eq("tmo_busy",  a_busy, TMO + 1);
        check_eq("tmo_pulse", {31'd0, a_tmo}, 32'd1);
        #1;
        check_eq("tmo_load",  load_data, 32'd0);
        check_eq("tmo_clear", {31'd0, err_timeout}, 32'd0);
        check_eq("tmo_state", {30'd0, dbg_state}, 32'd0);

        // Stray ack in IDLE
        step();
        mem_rdata = 32'hFFFFFFFF; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check_eq("stray_state", {30'd0, dbg_state}, 32'd0);
        check_eq("stray_req",   {31'd0, mem_req}, 32'd0);
        check_eq("stray_load",  load_data, 32'd0);

        // Reset in WAIT, ack one cycle after reset release
        step();
        datamemsel = 1'b1; read_write = 4'b0010; addr = 32'h300;
        step();
        #1;
        check_eq("mid_req",   {31'd0, mem_req}, 32'd1);
        check_eq("mid_state", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        step();
        #1;
        check_eq("mid_rst_req",  {31'd0, mem_req}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy_wait}, 32'd0);
        check_eq("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0; datamemsel = 1'b0;
        step();
        mem_rdata = 32'hCAFEF00D; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check_eq("late_ack_load",  load_data, 32'd0);
        check_eq("late_ack_req",   {31'd0, mem_req}, 32'd0);
        check_eq("late_ack_state", {30'd0, dbg_state}, 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
